pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage rv32i pipeline.
- Decides each cycle which pipeline registers load, when a bubble enters ID/EX, and when IF/ID is flushed.
- Handles three hazards: load-use hazards (the case the WB→MEM and EX/MEM forwarding paths cannot cover), I-cache/D-cache miss waits, and taken-branch/jump redirects.
- Sits beside the forwarding units. Drives the load enables of the PC and all stage registers.

Parameters:
- CNT_W, 32: width of each saturating performance counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ID_ctrlword  in  rv32i_control_word  decoded word of the instruction in ID; only opcode is used
- ID_rs1_num  in  5  rs1 field of the ID instruction
- ID_rs2_num  in  5  rs2 field of the ID instruction
- EX_ctrlword  in  rv32i_control_word  control word of the instruction in EX; uses opcode and load_regfile
- EX_rd_num  in  5  rd field of the EX instruction
- EX_br_taken  in  1  EX resolved a taken branch, jal or jalr
- icache_req  in  1  IF is requesting an instruction
- icache_resp  in  1  I-cache data valid this cycle
- dcache_req  in  1  MEM is issuing a read or write
- dcache_resp  in  1  D-cache access complete this cycle
- load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  register load enables
- bubble_id_ex  out  1  ID/EX loads a nop (all control zero) instead of ID contents
- flush_if_id  out  1  IF/ID loads a nop
- lu_stall_cnt, mem_stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - state=RUN; sticky flags i_done and d_done cleared; counters=0.
  - All load_* outputs =0; bubble_id_ex=1; flush_if_id=1.
- States are RUN and MEM_WAIT. Outputs are combinational from state and inputs; all other logic is registered.
- uses_rs1: true for every opcode except op_lui, op_auipc, op_jal.
- uses_rs2: true for op_reg, op_store, op_br only.
- Load-use hazard (lu) is true when all of these hold:
  - EX_ctrlword.opcode==op_load and EX_ctrlword.load_regfile
  - EX_rd_num != 0
  - (uses_rs1 and ID_rs1_num==EX_rd_num) or (uses_rs2 and ID_rs2_num==EX_rd_num)
- Miss pending (mem_busy):
  - (icache_req and not (icache_resp or i_done)) or (dcache_req and not (dcache_resp or d_done)).
- Priority order: mem_busy > EX_br_taken > lu.
- RUN, mem_busy=1:
  - All load_* =0 (full freeze).
  - Set i_done on icache_resp and d_done on dcache_resp.
  - Next state is MEM_WAIT.
  - mem_stall_cnt increments.
- MEM_WAIT:
  - Freeze continues; the sticky flags keep latching responses.
  - When mem_busy==0 (each requested cache has responded this cycle or earlier), apply the RUN rules below in this same cycle.
  - Clear both flags. Next state is RUN.
  - mem_stall_cnt increments on every frozen cycle.
- RUN/release cycle, branch taken (EX_br_taken=1):
  - All load_* =1; flush_if_id=1; bubble_id_ex=1.
  - Any lu is discarded, because the ID instruction is squashed.
  - flush_cnt increments.
- RUN/release cycle, lu=1 and no branch:
  - load_pc=0, load_if_id=0, load_id_ex=1, bubble_id_ex=1.
  - load_ex_mem=1, load_mem_wb=1.
  - lu_stall_cnt increments.
  - The next cycle sees the bubble in EX, so lu clears and the stall lasts exactly 1 cycle.
- Otherwise: all load_* =1; bubble_id_ex=0; flush_if_id=0.
- A branch held in EX during a freeze stays asserted, so the flush is taken on release. It is never lost and never applied twice.
- Counters saturate at all-ones and do not wrap.
- Reset asserted mid-MEM_WAIT clears the flags immediately. Late cache responses after reset are ignored unless a matching request is present.

Decomposition:
- rv32i_types already holds rv32i_control_word, rv32i_reg and the opcode enum.
- Add to rv32i_types: enum hz_state_t {RUN, MEM_WAIT}, and functions uses_rs1(rv32i_opcode) and uses_rs2(rv32i_opcode) so the forwarding units share them.
- One natural sub-module: sat_counter (parameter W, inputs inc/clk/rst_n), instantiated three times.

Test Plan:
- Load-use: EX=lw x5, ID=add x6,x5,x1.
  - One cycle with load_pc=0, load_if_id=0, bubble_id_ex=1.
  - Next cycle all load_*=1. lu_stall_cnt=1.
- No false hazard:
  - EX=lw x0, ID=add x6,x0,x0 → no stall.
  - EX=lw x5, ID=lui x5 → no stall.
  - EX=addi x5, ID=add x6,x5,x5 → no stall (left to forwarding).
- Split misses: icache_req and dcache_req high, icache_resp pulses at cycle 2, dcache_resp at cycle 5.
  - Freeze covers cycles 0-4; release at cycle 5.
  - mem_stall_cnt=6. i_done held over cycles 3-4.
- Branch plus load-use: EX_br_taken=1 with lu=1.
  - flush_if_id=1, bubble_id_ex=1, all loads=1.
  - lu_stall_cnt unchanged; flush_cnt=1.
- Branch during freeze: EX_br_taken=1 while dcache misses for 3 cycles.
  - Exactly one flush cycle, on the release cycle.
- Reset mid-MEM_WAIT: drop rst_n.
  - Outputs go to reset values immediately, not at a clock edge.
  - After release, with no requests, state=RUN and all loads=1.
- Saturation: force a counter to all-ones, then trigger another event → value unchanged.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared rv32i pipeline types, plus the hazard sequencer state and the
// register-usage predicates that the forwarding units also rely on.
package rv32i_types;

  typedef logic [4:0] rv32i_reg;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef struct packed {
    rv32i_opcode opcode;
    logic [2:0]  aluop;
    logic        load_regfile;
    logic        mem_read;
    logic        mem_write;
  } rv32i_control_word;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  function automatic logic uses_rs1(rv32i_opcode op);
    return !(op inside {op_lui, op_auipc, op_jal});
  endfunction

  function automatic logic uses_rs2(rv32i_opcode op);
    return op inside {op_reg, op_store, op_br};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage rv32i pipeline: freezes on cache
// misses, flushes on taken redirects, and inserts a bubble on load-use.
//
// state    | meaning
// RUN      | normal issue; load-use and redirect rules apply
// MEM_WAIT | pipeline frozen until every requested cache has responded
module pipeline_hazard_ctrl
  import rv32i_types::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  rv32i_control_word ID_ctrlword,
  input  rv32i_reg          ID_rs1_num,
  input  rv32i_reg          ID_rs2_num,
  input  rv32i_control_word EX_ctrlword,
  input  rv32i_reg          EX_rd_num,
  input  logic              EX_br_taken,
  input  logic              icache_req,
  input  logic              icache_resp,
  input  logic              dcache_req,
  input  logic              dcache_resp,
  output logic              load_pc,
  output logic              load_if_id,
  output logic              load_id_ex,
  output logic              load_ex_mem,
  output logic              load_mem_wb,
  output logic              bubble_id_ex,
  output logic              flush_if_id,
  output logic [CNT_W-1:0]  lu_stall_cnt,
  output logic [CNT_W-1:0]  mem_stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  hz_state_t state_q, state_d;
  logic      i_done_q, i_done_d;
  logic      d_done_q, d_done_d;
  logic      mem_busy;
  logic      lu;
  logic      lu_inc, mem_inc, flush_inc;
  logic      unused_ctrl;

  // Only the opcode and load_regfile fields matter here.
  assign unused_ctrl = ^{ID_ctrlword, EX_ctrlword};

  assign mem_busy = (icache_req && !(icache_resp || i_done_q)) ||
                    (dcache_req && !(dcache_resp || d_done_q));

  assign lu = (EX_ctrlword.opcode == op_load) && EX_ctrlword.load_regfile &&
              (EX_rd_num != 5'd0) &&
              ((uses_rs1(ID_ctrlword.opcode) && (ID_rs1_num == EX_rd_num)) ||
               (uses_rs2(ID_ctrlword.opcode) && (ID_rs2_num == EX_rd_num)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_done_q <= i_done_d;
      d_done_q <= d_done_d;
    end
  end

  // Flags only latch a response that answers a live request.
  always_comb begin
    state_d  = state_q;
    i_done_d = i_done_q;
    d_done_d = d_done_q;
    case (state_q)
      RUN: begin
        if (mem_busy) begin
          state_d  = MEM_WAIT;
          i_done_d = i_done_q | (icache_req & icache_resp);
          d_done_d = d_done_q | (dcache_req & dcache_resp);
        end
      end
      MEM_WAIT: begin
        if (mem_busy) begin
          i_done_d = i_done_q | (icache_req & icache_resp);
          d_done_d = d_done_q | (dcache_req & dcache_resp);
        end else begin
          state_d  = RUN;
          i_done_d = 1'b0;
          d_done_d = 1'b0;
        end
      end
      default: begin
        state_d  = RUN;
        i_done_d = 1'b0;
        d_done_d = 1'b0;
      end
    endcase
  end

  // The release cycle out of MEM_WAIT still counts as a stall cycle.
  always_comb begin
    load_pc      = 1'b1;
    load_if_id   = 1'b1;
    load_id_ex   = 1'b1;
    load_ex_mem  = 1'b1;
    load_mem_wb  = 1'b1;
    bubble_id_ex = 1'b0;
    flush_if_id  = 1'b0;
    lu_inc       = 1'b0;
    flush_inc    = 1'b0;
    mem_inc      = mem_busy || (state_q == MEM_WAIT);
    if (!rst_n) begin
      load_pc      = 1'b0;
      load_if_id   = 1'b0;
      load_id_ex   = 1'b0;
      load_ex_mem  = 1'b0;
      load_mem_wb  = 1'b0;
      bubble_id_ex = 1'b1;
      flush_if_id  = 1'b1;
      mem_inc      = 1'b0;
    end else if (mem_busy) begin
      load_pc      = 1'b0;
      load_if_id   = 1'b0;
      load_id_ex   = 1'b0;
      load_ex_mem  = 1'b0;
      load_mem_wb  = 1'b0;
    end else if (EX_br_taken) begin
      bubble_id_ex = 1'b1;
      flush_if_id  = 1'b1;
      flush_inc    = 1'b1;
    end else if (lu) begin
      load_pc      = 1'b0;
      load_if_id   = 1'b0;
      bubble_id_ex = 1'b1;
      lu_inc       = 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_lu_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (lu_inc),
    .cnt_o (lu_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mem_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (mem_inc),
    .cnt_o (mem_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (flush_inc),
    .cnt_o (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and randomized bench for pipeline_hazard_ctrl against a
// cycle-level behavioural model of the stall/flush rules.
module tb_pipeline_hazard_ctrl;
  import rv32i_types::*;

  localparam int W = 5;
  localparam int CMAX = (1 << W) - 1;

  logic              clk;
  logic              rst_n;
  rv32i_control_word ID_ctrlword, EX_ctrlword;
  rv32i_reg          ID_rs1_num, ID_rs2_num, EX_rd_num;
  logic              EX_br_taken;
  logic              icache_req, icache_resp, dcache_req, dcache_resp;
  logic              load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic              bubble_id_ex, flush_if_id;
  logic [W-1:0]      lu_stall_cnt, mem_stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;

  // model state: inside a miss episode, which caches already answered, counts
  bit m_wait, m_iseen, m_dseen;
  int m_lu_n, m_mem_n, m_fl_n;
  // pending model update computed before the edge
  bit p_busy, p_br, p_lu;

  pipeline_hazard_ctrl #(.CNT_W(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ID_ctrlword   (ID_ctrlword),
    .ID_rs1_num    (ID_rs1_num),
    .ID_rs2_num    (ID_rs2_num),
    .EX_ctrlword   (EX_ctrlword),
    .EX_rd_num     (EX_rd_num),
    .EX_br_taken   (EX_br_taken),
    .icache_req    (icache_req),
    .icache_resp   (icache_resp),
    .dcache_req    (dcache_req),
    .dcache_resp   (dcache_resp),
    .load_pc       (load_pc),
    .load_if_id    (load_if_id),
    .load_id_ex    (load_id_ex),
    .load_ex_mem   (load_ex_mem),
    .load_mem_wb   (load_mem_wb),
    .bubble_id_ex  (bubble_id_ex),
    .flush_if_id   (flush_if_id),
    .lu_stall_cnt  (lu_stall_cnt),
    .mem_stall_cnt (mem_stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic rv32i_control_word cw(input rv32i_opcode op, input logic ld);
    rv32i_control_word c;
    c = '0;
    c.opcode = op;
    c.load_regfile = ld;
    return c;
  endfunction

  function automatic bit reads_rs1(input rv32i_opcode op);
    case (op)
      op_lui, op_auipc, op_jal: return 1'b0;
      default:                  return 1'b1;
    endcase
  endfunction

  function automatic bit reads_rs2(input rv32i_opcode op);
    case (op)
      op_reg, op_store, op_br: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_reset();
    m_wait = 0; m_iseen = 0; m_dseen = 0;
    m_lu_n = 0; m_mem_n = 0; m_fl_n = 0;
  endtask

  task automatic idle_inputs();
    ID_ctrlword = '0; EX_ctrlword = '0;
    ID_rs1_num = '0; ID_rs2_num = '0; EX_rd_num = '0;
    EX_br_taken = 0;
    icache_req = 0; icache_resp = 0; dcache_req = 0; dcache_resp = 0;
  endtask

  // One cycle: check combinational outputs mid-cycle against the model,
  // cross the clock edge, then check the counters.
  task automatic step();
    bit [4:0] le;
    bit bub, fl;
    #1;
    p_busy = (icache_req && !icache_resp && !m_iseen) ||
             (dcache_req && !dcache_resp && !m_dseen);
    p_br = EX_br_taken;
    p_lu = (EX_ctrlword.opcode == op_load) && EX_ctrlword.load_regfile &&
           (EX_rd_num != 0) &&
           ((reads_rs1(ID_ctrlword.opcode) && ID_rs1_num == EX_rd_num) ||
            (reads_rs2(ID_ctrlword.opcode) && ID_rs2_num == EX_rd_num));
    if (p_busy)    begin le = 5'b00000; bub = 0; fl = 0; end
    else if (p_br) begin le = 5'b11111; bub = 1; fl = 1; end
    else if (p_lu) begin le = 5'b00111; bub = 1; fl = 0; end
    else           begin le = 5'b11111; bub = 0; fl = 0; end
    chk("load_pc", int'(load_pc), int'(le[4]));
    chk("load_if_id", int'(load_if_id), int'(le[3]));
    chk("load_id_ex", int'(load_id_ex), int'(le[2]));
    chk("load_ex_mem", int'(load_ex_mem), int'(le[1]));
    chk("load_mem_wb", int'(load_mem_wb), int'(le[0]));
    chk("bubble_id_ex", int'(bubble_id_ex), int'(bub));
    chk("flush_if_id", int'(flush_if_id), int'(fl));
    @(posedge clk);
    if (p_busy || m_wait) m_mem_n = sat(m_mem_n + 1);
    if (p_busy) begin
      m_wait = 1;
      m_iseen = m_iseen | (icache_req & icache_resp);
      m_dseen = m_dseen | (dcache_req & dcache_resp);
    end else begin
      m_wait = 0; m_iseen = 0; m_dseen = 0;
      if (p_br) m_fl_n = sat(m_fl_n + 1);
      else if (p_lu) m_lu_n = sat(m_lu_n + 1);
    end
    #1;
    chk("lu_stall_cnt", int'(lu_stall_cnt), m_lu_n);
    chk("mem_stall_cnt", int'(mem_stall_cnt), m_mem_n);
    chk("flush_cnt", int'(flush_cnt), m_fl_n);
  endtask

  task automatic set_lu();
    EX_ctrlword = cw(op_load, 1'b1); EX_rd_num = 5;
    ID_ctrlword = cw(op_reg, 1'b1); ID_rs1_num = 5; ID_rs2_num = 1;
  endtask

  initial begin
    rv32i_opcode ops[10];
    int nflush;
    ops = '{op_lui, op_auipc, op_jal, op_jalr, op_br, op_load, op_store,
            op_imm, op_reg, op_csr};
    model_reset();
    idle_inputs();
    rst_n = 0;
    #2;
    chk("rst_load_pc", int'(load_pc), 0);
    chk("rst_load_mem_wb", int'(load_mem_wb), 0);
    chk("rst_bubble", int'(bubble_id_ex), 1);
    chk("rst_flush", int'(flush_if_id), 1);
    chk("rst_mem_cnt", int'(mem_stall_cnt), 0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1;
    @(posedge clk); #1;

    step();
    // load-use: lw x5 in EX, add x6,x5,x1 in ID
    set_lu();
    #1;
    chk("lu_load_pc", int'(load_pc), 0);
    chk("lu_load_if_id", int'(load_if_id), 0);
    chk("lu_bubble", int'(bubble_id_ex), 1);
    step();
    EX_ctrlword = '0; EX_rd_num = 0;
    #1;
    chk("lu_after_load_pc", int'(load_pc), 1);
    step();
    chk("lu_cnt_one", int'(lu_stall_cnt), 1);

    // no false hazards
    EX_ctrlword = cw(op_load, 1'b1); EX_rd_num = 0;
    ID_ctrlword = cw(op_reg, 1'b1); ID_rs1_num = 0; ID_rs2_num = 0;
    #1; chk("nf_x0_load_pc", int'(load_pc), 1);
    step();
    EX_rd_num = 5; ID_ctrlword = cw(op_lui, 1'b1); ID_rs1_num = 5; ID_rs2_num = 5;
    #1; chk("nf_lui_load_pc", int'(load_pc), 1);
    step();
    EX_ctrlword = cw(op_imm, 1'b1); ID_ctrlword = cw(op_reg, 1'b1);
    #1; chk("nf_alu_load_pc", int'(load_pc), 1);
    step();
    idle_inputs();

    // split misses: I answers at cycle 2, D at cycle 5
    icache_req = 1; dcache_req = 1;
    for (int c = 0; c < 6; c++) begin
      icache_resp = (c == 2); dcache_resp = (c == 5);
      #1;
      chk("split_load_pc", int'(load_pc), (c == 5) ? 1 : 0);
      if (c == 3 || c == 4) chk("split_i_done", int'(dut.i_done_q), 1);
      step();
    end
    idle_inputs();
    chk("split_mem_cnt", int'(mem_stall_cnt), 6);

    // branch plus load-use: redirect wins, lu discarded
    set_lu(); EX_br_taken = 1;
    #1;
    chk("brlu_flush", int'(flush_if_id), 1);
    chk("brlu_bubble", int'(bubble_id_ex), 1);
    chk("brlu_load_pc", int'(load_pc), 1);
    step();
    chk("brlu_lu_cnt", int'(lu_stall_cnt), 1);
    chk("brlu_flush_cnt", int'(flush_cnt), 1);
    idle_inputs();

    // branch held during a 3-cycle D miss: exactly one flush on release
    nflush = 0;
    EX_br_taken = 1; dcache_req = 1;
    for (int c = 0; c < 4; c++) begin
      dcache_resp = (c == 3);
      #1;
      if (flush_if_id) nflush++;
      chk("brfz_flush", int'(flush_if_id), (c == 3) ? 1 : 0);
      step();
    end
    chk("brfz_nflush", nflush, 1);
    chk("brfz_flush_cnt", int'(flush_cnt), 2);
    idle_inputs();

    // reset in the middle of MEM_WAIT
    icache_req = 1; icache_resp = 0; dcache_req = 1; dcache_resp = 1;
    step(); step();
    #2;
    rst_n = 0;
    #1;
    chk("amid_load_pc", int'(load_pc), 0);
    chk("amid_load_ex_mem", int'(load_ex_mem), 0);
    chk("amid_bubble", int'(bubble_id_ex), 1);
    chk("amid_flush", int'(flush_if_id), 1);
    chk("amid_d_done", int'(dut.d_done_q), 0);
    chk("amid_mem_cnt", int'(mem_stall_cnt), 0);
    idle_inputs(); icache_resp = 1; dcache_resp = 1;
    @(posedge clk); #1;
    chk("amid_held_flag", int'(dut.d_done_q), 0);
    rst_n = 1;
    model_reset();
    step();
    chk("amid_state_run", int'(dut.state_q == RUN), 1);
    chk("amid_rel_load_pc", int'(load_pc), 1);
    // late response with no request must not count
    idle_inputs(); dcache_resp = 1;
    step();
    dcache_resp = 0; dcache_req = 1;
    #1; chk("late_resp_busy", int'(load_pc), 0);
    step();
    dcache_resp = 1;
    step();
    idle_inputs();

    // saturation of lu_stall_cnt at 2^W-1
    for (int k = 0; k < 34; k++) begin
      set_lu(); step();
      idle_inputs(); step();
    end
    chk("sat_lu_cnt", int'(lu_stall_cnt), CMAX);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      EX_ctrlword = cw(ops[$urandom_range(0, 9)], 1'($urandom_range(0, 3) != 0));
      ID_ctrlword = cw(ops[$urandom_range(0, 9)], 1'b1);
      EX_rd_num   = 5'($urandom_range(0, 3));
      ID_rs1_num  = 5'($urandom_range(0, 3));
      ID_rs2_num  = 5'($urandom_range(0, 3));
      EX_br_taken = ($urandom_range(0, 7) == 0);
      icache_req  = ($urandom_range(0, 3) != 0);
      icache_resp = ($urandom_range(0, 2) == 0);
      dcache_req  = ($urandom_range(0, 2) == 0);
      dcache_resp = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
